multicycle_decode: RTL and testbench

- Moore-style control FSM plus ALU/flag decoder for the multicycle ARM datapath; successor to the single-cycle decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback cycles, and drives the datapath mux selects and write strobes.
- Adds a parametrised ALU control width, an illegal-opcode flag and a retired-instruction counter.
- Sits between the instruction register and the condition-check unit; RegW/MemW/PCS are raw and still gated by the condition logic.

---
 rtl/multicycle_decode.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_decode.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_decode.sv
// multicycle_decode: Moore control FSM and ALU/flag decoder for the multicycle ARM datapath.
// Sequences each instruction through fetch/decode/execute/memory/writeback and drives the
// datapath selects and raw write strobes. RegW/MemW/PCS are raw, so the condition-check unit
// must still gate them.
//
// Optional feature: define MULTICYCLE_DECODE_MEM_WAIT_EN to add the MemReady input. FETCH,
// MEMRD and MEMWR then stall while MemReady=0. Without the macro, memory is always ready.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   MemReady         memory handshake (only with MULTICYCLE_DECODE_MEM_WAIT_EN)
//   Op, Funct, Rd    instr[27:26], instr[25:20], instr[15:12]
//   IRWrite, NextPC  instruction register load, unconditional PC write
//   AdrSrc, ALUSrcA, ALUSrcB, ResultSrc   datapath mux selects
//   RegW, MemW, PCS  raw register write, memory write, PC-source strobes
//   FlagW            [1] NZ write, [0] CV write
//   ImmSrc, RegSrc, ByteSrc   combinational decodes of Op/Funct
//   ALUControl       ALU operation, zero-extended to ALUCTRL_W
//   Illegal          one-cycle pulse on an undecodable instruction
//   InstrCount       retired-instruction counter (wraps)
//   State            current FSM state, for debug
module multicycle_decode #(
  parameter int unsigned ALUCTRL_W = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef MULTICYCLE_DECODE_MEM_WAIT_EN
  input  logic                 MemReady,
`endif
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  output logic                 IRWrite,
  output logic                 NextPC,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 PCS,
  output logic [1:0]           FlagW,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic                 ByteSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Illegal,
  output logic [CNT_W-1:0]     InstrCount,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_ready;
  logic             retire;

  logic             ir_write, next_pc, reg_w, mem_w, branch, alu_op;
  logic             alu_bad, alu_addsub, decode_bad;
  logic [2:0]       alu_ctrl;
  logic [1:0]       flag_w;

`ifdef MULTICYCLE_DECODE_MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? StExecuteI : StExecuteR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;  // undecodable: abandon without retiring
        endcase
      end
      StMemAdr:   state_d = Funct[0] ? StMemRd : StMemWr;
      StMemRd:    if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWr:    if (mem_ready) state_d = StFetch;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      default:    state_d = StFetch;
    endcase
  end

  // An instruction retires only when a completing state hands back to FETCH.
  always_comb begin
    retire = (state_d == StFetch) &&
             ((state_q == StMemWb) || (state_q == StMemWr) ||
              (state_q == StAluWb) || (state_q == StBranch));
    cnt_d  = retire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    ir_write  = 1'b0;
    next_pc   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    unique case (state_q)
      StFetch: begin
        ir_write  = mem_ready;
        next_pc   = mem_ready;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StDecode: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StMemAdr:   ALUSrcB = 2'b01;
      StMemRd:    AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      StMemWr: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;  // held for the whole memory wait
      end
      StExecuteR: alu_op = 1'b1;
      StExecuteI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      StAluWb:    reg_w = 1'b1;
      StBranch: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU and flag decode, only meaningful in the execute states.
  always_comb begin
    alu_ctrl   = 3'd0;
    alu_bad    = 1'b0;
    alu_addsub = 1'b0;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0100: begin alu_ctrl = 3'd0; alu_addsub = 1'b1; end
        4'b0010: begin alu_ctrl = 3'd1; alu_addsub = 1'b1; end
        4'b0000: alu_ctrl = 3'd2;
        4'b1100: alu_ctrl = 3'd3;
        4'b0001: alu_ctrl = 3'd6;
        default: alu_bad = 1'b1;
      endcase
      if (!alu_bad) flag_w = {Funct[0], Funct[0] & alu_addsub};
    end
  end

  assign decode_bad = (state_q == StDecode) && (Op == 2'b11);

  // Strobes are forced low while reset is held; selects already show FETCH values then.
  assign IRWrite    = reset & ir_write;
  assign NextPC     = reset & next_pc;
  assign RegW       = reset & reg_w;
  assign MemW       = reset & mem_w;
  assign PCS        = reset & (branch | ((Rd == 4'hF) & reg_w));
  assign Illegal    = reset & (decode_bad | (alu_op & alu_bad));
  assign FlagW      = flag_w;
  assign ALUControl = ALUCTRL_W'(alu_ctrl);

  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01) & ~Funct[0], Op == 2'b10};
  assign ByteSrc    = Funct[2];
  assign InstrCount = cnt_q;
  assign State      = state_q;

endmodule

// File: tb/tb_multicycle_decode.sv
// Directed bench for multicycle_decode. Each instruction is expanded into its expected
// per-cycle trace (state list by instruction class, outputs per phase); a negedge process
// compares the DUT against that trace every cycle. Literal checks pin retirement counts
// and reset behaviour.
module tb_multicycle_decode;

  localparam int unsigned AW = 4;
  localparam int unsigned CW = 8;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    op    = 2'b00;
  logic [5:0]    funct = 6'd0;
  logic [3:0]    rd    = 4'd0;
`ifdef MULTICYCLE_DECODE_MEM_WAIT_EN
  logic          mem_ready = 1'b1;
`endif

  logic          IRWrite, NextPC, AdrSrc, ALUSrcA, RegW, MemW, PCS, ByteSrc, Illegal;
  logic [1:0]    ALUSrcB, ResultSrc, FlagW, ImmSrc, RegSrc;
  logic [AW-1:0] ALUControl;
  logic [CW-1:0] InstrCount;
  logic [3:0]    State;

  multicycle_decode #(
    .ALUCTRL_W(AW),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef MULTICYCLE_DECODE_MEM_WAIT_EN
    .MemReady  (mem_ready),
`endif
    .Op        (op),
    .Funct     (funct),
    .Rd        (rd),
    .IRWrite   (IRWrite),
    .NextPC    (NextPC),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .RegW      (RegW),
    .MemW      (MemW),
    .PCS       (PCS),
    .FlagW     (FlagW),
    .ImmSrc    (ImmSrc),
    .RegSrc    (RegSrc),
    .ByteSrc   (ByteSrc),
    .ALUControl(ALUControl),
    .Illegal   (Illegal),
    .InstrCount(InstrCount),
    .State     (State)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       st;
    bit       irw, npc, adr, asa;
    bit [1:0] asb, rs;
    bit       regw, memw, pcs;
    bit [1:0] flagw, imm, regsrc;
    bit       bytesrc;
    int       aluc;
    bit       ill;
    int       cnt;
  } exp_t;

  exp_t expq[$];
  int   checks    = 0;
  int   failures  = 0;
  int   model_cnt = 0;
  int   cyc       = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp_v);
    end
  endtask

  // Expected outputs for one cycle of phase st (0 FETCH .. 9 BRANCH) of the current instruction.
  function automatic exp_t model(input int st, input bit rdy);
    exp_t e;
    bit   addsub;
    e = '{default: 0};
    addsub    = 1'b0;
    e.st      = st;
    e.imm     = op;
    e.regsrc  = {(op == 2'b01) && !funct[0], op == 2'b10};
    e.bytesrc = funct[2];
    e.cnt     = model_cnt % (1 << CW);
    case (st)
      0: begin e.irw = rdy; e.npc = rdy; e.asa = 1; e.asb = 2; e.rs = 2; end
      1: begin e.asa = 1; e.asb = 2; e.rs = 2; e.ill = (op == 2'b11); end
      2: e.asb = 1;
      3: e.adr = 1;
      4: begin e.rs = 1; e.regw = 1; end
      5: begin e.adr = 1; e.memw = 1; end
      6, 7: begin
        e.asb = (st == 7) ? 2'd1 : 2'd0;
        case (funct[4:1])
          4'd4:    begin e.aluc = 0; addsub = 1; end  // ADD
          4'd2:    begin e.aluc = 1; addsub = 1; end  // SUB
          4'd0:    e.aluc = 2;                        // AND
          4'd12:   e.aluc = 3;                        // ORR
          4'd1:    e.aluc = 6;                        // EOR
          default: e.ill = 1;
        endcase
        if (!e.ill) e.flagw = {funct[0], funct[0] & addsub};
      end
      8: e.regw = 1;
      9: begin e.asb = 1; e.rs = 2; e.pcs = 1; end
      default: ;
    endcase
    if (e.regw && rd == 4'd15) e.pcs = 1;
    return e;
  endfunction

  function automatic exp_t model_rst();
    exp_t e;
    e      = model(0, 1'b1);
    e.irw  = 0;
    e.npc  = 0;
    e.cnt  = 0;
    return e;
  endfunction

  always @(negedge clk) begin : cmp
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      cyc++;
      chk("State", int'(State), e.st);
      chk("IRWrite", int'(IRWrite), int'(e.irw));
      chk("NextPC", int'(NextPC), int'(e.npc));
      chk("AdrSrc", int'(AdrSrc), int'(e.adr));
      chk("ALUSrcA", int'(ALUSrcA), int'(e.asa));
      chk("ALUSrcB", int'(ALUSrcB), int'(e.asb));
      chk("ResultSrc", int'(ResultSrc), int'(e.rs));
      chk("RegW", int'(RegW), int'(e.regw));
      chk("MemW", int'(MemW), int'(e.memw));
      chk("PCS", int'(PCS), int'(e.pcs));
      chk("FlagW", int'(FlagW), int'(e.flagw));
      chk("ImmSrc", int'(ImmSrc), int'(e.imm));
      chk("RegSrc", int'(RegSrc), int'(e.regsrc));
      chk("ByteSrc", int'(ByteSrc), int'(e.bytesrc));
      chk("ALUControl", int'(ALUControl), e.aluc);
      chk("Illegal", int'(Illegal), int'(e.ill));
      chk("InstrCount", int'(InstrCount), e.cnt);
    end
  end

  // Called at posedge+1 (or later in the same cycle with reset already low).
  task automatic do_reset(input int n);
    reset     = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < n; i++) begin
      expq.push_back(model_rst());
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  // Called at posedge+1 with the DUT in FETCH. fwait/mwait are stall cycles in FETCH and
  // in MEMRD/MEMWR (only meaningful with the memory-wait feature).
  task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                           input int fwait, input int mwait);
    int sts[$];
    op    = o;
    funct = f;
    rd    = r;
    if (o == 2'b01)      sts = f[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
    else if (o == 2'b00) sts = f[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
    else if (o == 2'b10) sts = '{0, 1, 9};
    else                 sts = '{0, 1};
    foreach (sts[i]) begin
      int nw;
      nw = (sts[i] == 0) ? fwait : ((sts[i] == 3 || sts[i] == 5) ? mwait : 0);
      for (int w = 0; w <= nw; w++) begin
`ifdef MULTICYCLE_DECODE_MEM_WAIT_EN
        mem_ready = (w == nw);
`endif
        expq.push_back(model(sts[i], w == nw));
        @(posedge clk);
        #1;
      end
    end
    if (o != 2'b11) model_cnt++;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("reset State literal", int'(State), 0);
    chk("reset InstrCount literal", int'(InstrCount), 0);
    chk("reset IRWrite literal", int'(IRWrite), 0);
    chk("reset ALUSrcB literal", int'(ALUSrcB), 2);
    do_reset(3);

    run_instr(2'b00, 6'b001000, 4'd3, 0, 0);   // ADD reg
    chk("count after ADD", int'(InstrCount), 1);
    run_instr(2'b01, 6'b011101, 4'd2, 0, 0);   // LDRB
    chk("count after LDRB", int'(InstrCount), 2);
    run_instr(2'b00, 6'b100101, 4'd15, 0, 0);  // SUBS imm, Rd=15
    chk("count after SUBS", int'(InstrCount), 3);
    run_instr(2'b11, 6'b000000, 4'd0, 0, 0);   // undecodable Op
    chk("count after Op=11", int'(InstrCount), 3);
    run_instr(2'b00, 6'b001111, 4'd1, 0, 0);   // undefined cmd 0111
    chk("count after bad cmd", int'(InstrCount), 4);
    run_instr(2'b01, 6'b011000, 4'd5, 0, 0);   // STR
    run_instr(2'b10, 6'b101000, 4'd0, 0, 0);   // B
    run_instr(2'b00, 6'b000011, 4'd6, 0, 0);   // EORS reg
    run_instr(2'b00, 6'b111000, 4'd7, 0, 0);   // ORR imm
    run_instr(2'b00, 6'b000001, 4'd8, 0, 0);   // ANDS reg
    run_instr(2'b01, 6'b011001, 4'd15, 0, 0);  // LDR to PC
    chk("count after LDR pc", int'(InstrCount), 10);
`ifdef MULTICYCLE_DECODE_MEM_WAIT_EN
    run_instr(2'b01, 6'b011000, 4'd1, 2, 3);   // STR with fetch and memory waits
    chk("count after waited STR", int'(InstrCount), 11);
    mem_ready = 1'b1;
`endif

    // Reset in the middle of MEMRD abandons the load.
    op    = 2'b01;
    funct = 6'b011001;
    rd    = 4'd4;
    expq.push_back(model(0, 1'b1));
    @(posedge clk);
    #1;
    expq.push_back(model(1, 1'b1));
    @(posedge clk);
    #1;
    expq.push_back(model(2, 1'b1));
    @(posedge clk);
    #1;
    chk("mid State literal", int'(State), 3);
    chk("mid AdrSrc literal", int'(AdrSrc), 1);
    #1 reset = 1'b0;
    #1;
    chk("async State literal", int'(State), 0);
    chk("async RegW literal", int'(RegW), 0);
    chk("async InstrCount literal", int'(InstrCount), 0);
    do_reset(2);

    // Counter wrap.
    for (int i = 0; i < 255; i++) run_instr(2'b10, 6'b100000, 4'd0, 0, 0);
    chk("count before wrap", int'(InstrCount), 255);
    run_instr(2'b10, 6'b100000, 4'd0, 0, 0);
    chk("count after wrap", int'(InstrCount), 0);
    chk("trace drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
